// File: rtl/apb_master.sv
// ============================================================================
// Module   : apb_master
// Purpose  : Single-outstanding APB initiator. A valid/ready command port is
//            turned into one APB SETUP + ACCESS transfer. Completion status is
//            returned on a one-cycle response strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_write         1 = write, 0 = read
//   cmd_addr          transfer address
//   cmd_wdata         write data
//   rsp_valid         one-cycle completion strobe
//   rsp_rdata         read data (0 for writes and timeouts)
//   rsp_timeout       transfer aborted by the watchdog (qualified by rsp_valid)
//   paddr/pwrite/psel/penable/pwdata   APB request signals
//   prdata/pready     APB completion signals
// ----------------------------------------------------------------------------
// Configuration macro:
//   APB_MASTER_TIMEOUT_EN  when defined, a wait counter aborts an ACCESS
//                          phase that lasts TIMEOUT_CYCLES cycles without
//                          pready. When undefined, ACCESS waits forever and
//                          rsp_timeout is tied low.
// ============================================================================
`default_nettype none

module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  // APB side
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state;

  // Abort request from the watchdog; constant 0 when the watchdog is absent.
  logic abort;

  // The watchdog limit must fit the 8-bit wait counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
    $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  // Only one transfer is ever outstanding, so readiness is simply "idle".
  assign cmd_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Watchdog: counts ACCESS cycles that end without pready. The abort fires
  // on the edge at which the count would reach the limit, so with a limit of
  // N the transfer is dropped after exactly N unready ACCESS cycles. A pready
  // on that same edge wins and completes the transfer normally.
  // --------------------------------------------------------------------------
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;

  assign wait_cnt_next = wait_cnt + 8'd1;
  assign abort         = (state == ACCESS) && !pready &&
                         (wait_cnt_next == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (state == SETUP) begin
      // cleared on the way into ACCESS
      wait_cnt <= 8'd0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= wait_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_timeout <= 1'b0;
    end else begin
      rsp_timeout <= abort;
    end
  end
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Main transfer sequencer. The APB request fields are loaded once at
  // command acceptance and then held untouched (including through IDLE), so
  // they are stable for the whole SETUP/ACCESS window.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // response is a single-cycle strobe unless set below
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            state     <= IDLE;
          end else if (abort) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none

module tb_apb_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic [7:0] paddr;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .psel        (psel),
    .penable     (penable),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; observe/drive 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({psel, penable, rsp_valid, rsp_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: psel/penable/rsp_valid/rsp_timeout=%b expected 0000",
               {psel, penable, rsp_valid, rsp_timeout});
    end
    checks++;
    if ({paddr, pwrite, pwdata, rsp_rdata} !== 25'd0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwrite=%b pwdata=%h rsp_rdata=%h expected all 0",
               paddr, pwrite, pwdata, rsp_rdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b psel=%b expected 1/0", cmd_ready, psel);
    end
  endtask

  task automatic test_zero_wait_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'hA5;
    pready    = 1'b1; prdata    = 8'h77;
    step();                         // accept edge N
    cmd_valid = 1'b0; cmd_wdata = 8'h00;
    checks++;                       // cycle N+1: SETUP
    if ({psel, penable, pwrite} !== 3'b101 || paddr !== 8'h10 || pwdata !== 8'hA5 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h cmd_ready=%b expected 1 0 1 10 A5 0",
               psel, penable, pwrite, paddr, pwdata, cmd_ready);
    end
    step();
    checks++;                       // cycle N+2: ACCESS
    if ({psel, penable} !== 2'b11 || paddr !== 8'h10 || pwdata !== 8'hA5 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_access: psel=%b penable=%b paddr=%h pwdata=%h rsp_valid=%b expected 1 1 10 A5 0",
               psel, penable, paddr, pwdata, rsp_valid);
    end
    step();
    checks++;                       // cycle N+3: response
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_timeout !== 1'b0 ||
        psel !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_rsp: rsp_valid=%b rsp_rdata=%h rsp_timeout=%b psel=%b cmd_ready=%b expected 1 00 0 0 1",
               rsp_valid, rsp_rdata, rsp_timeout, psel, cmd_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || paddr !== 8'h10 || pwdata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_after: rsp_valid=%b paddr=%h pwdata=%h expected 0 10 A5 (held)",
               rsp_valid, paddr, pwdata);
    end
  endtask

  task automatic test_read_wait();
    int pen_cnt = 0;
    int rsp_at  = -1;
    logic [7:0] rdat = 8'h00;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
    pready    = 1'b0; prdata    = 8'hA5;
    step();                         // accept edge N
    cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (penable === 1'b1) pen_cnt++;
      if (rsp_valid === 1'b1 && rsp_at < 0) begin
        rsp_at = c;
        rdat   = rsp_rdata;
      end
      pready = (c == 5);            // ACCESS cycles N+2..N+4 unready, N+5 ready
      step();
    end
    pready = 1'b0;
    checks++;
    if (pen_cnt != 4) begin
      errors++;
      $display("FAIL rd_penable_cycles: got %0d expected 4", pen_cnt);
    end
    checks++;
    if (rsp_at != 6) begin
      errors++;
      $display("FAIL rd_latency: rsp_valid at +%0d expected +6", rsp_at);
    end
    checks++;
    if (rdat !== 8'hA5) begin
      errors++;
      $display("FAIL rd_data: rsp_rdata=%h expected A5", rdat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [4] = '{8'h21, 8'h42, 8'h63, 8'h84};
    logic       wrs   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int acc_cyc [4];
    int n_acc   = 0;
    int n_rsp   = 0;
    int rsp_idx = 0;
    int bad_rsp = 0;
    int bad_adr = 0;
    int last_acc = -10;
    pready = 1'b1; prdata = 8'h3C;
    cmd_valid = 1'b1; cmd_write = wrs[0]; cmd_addr = addrs[0]; cmd_wdata = 8'h5A;
    for (int c = 0; c < 40 && n_rsp < 4; c++) begin
      if (rsp_valid === 1'b1) begin
        if (rsp_rdata !== (wrs[rsp_idx] ? 8'h00 : 8'h3C) || psel !== 1'b0) bad_rsp++;
        rsp_idx++;
        n_rsp++;
      end
      if (c == last_acc + 1 && paddr !== addrs[n_acc-1]) bad_adr++;
      if (cmd_valid && cmd_ready === 1'b1) begin
        acc_cyc[n_acc] = c;
        last_acc = c;
        n_acc++;
        step();
        if (n_acc < 4) begin
          cmd_write = wrs[n_acc]; cmd_addr = addrs[n_acc];
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        step();
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (n_acc != 4 || n_rsp != 4) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d responses=%0d expected 4/4", n_acc, n_rsp);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          errors++;
          $display("FAIL b2b_interval%0d: got %0d expected 3", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    checks++;
    if (bad_rsp != 0 || bad_adr != 0) begin
      errors++;
      $display("FAIL b2b_content: bad responses=%0d bad setup addresses=%0d expected 0/0", bad_rsp, bad_adr);
    end
  endtask

  task automatic test_reset_mid_access();
    int spurious = 0;
    int rsp_at   = -1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();                         // ACCESS
    step();                         // still ACCESS
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b000 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: psel=%b penable=%b rsp_valid=%b cmd_ready=%b expected 0 0 0 1",
               psel, penable, rsp_valid, cmd_ready);
    end
    pready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid === 1'b1 || psel === 1'b1) spurious++;
      step();
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rst_no_rsp: spurious activity cycles=%0d expected 0", spurious);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h66; cmd_wdata = 8'h99;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 6 && rsp_at < 0; c++) begin
      if (rsp_valid === 1'b1) rsp_at = c;
      else step();
    end
    checks++;
    if (rsp_at != 3 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: response at +%0d timeout=%b expected +3 0", rsp_at, rsp_timeout);
    end
    step();
  endtask

  task automatic test_timeout();
    int rsp_at  = -1;
    int pen_cnt = 0;
    logic tout  = 1'b0;
    logic [7:0] rdat = 8'hEE;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h70;
    pready = 1'b0; prdata = 8'hFF;
    step();
    cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int c = 1; c <= 20 && rsp_at < 0; c++) begin
      if (penable === 1'b1) pen_cnt++;
      if (rsp_valid === 1'b1) begin
        rsp_at = c;
        tout   = rsp_timeout;
        rdat   = rsp_rdata;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
          errors++;
          $display("FAIL to_bus_drop: psel=%b penable=%b expected 0 0", psel, penable);
        end
      end else begin
        step();
      end
    end
    checks++;
    if (rsp_at != 6 || pen_cnt != 4) begin
      errors++;
      $display("FAIL to_latency: rsp at +%0d penable cycles=%0d expected +6 and 4", rsp_at, pen_cnt);
    end
    checks++;
    if (tout !== 1'b1 || rdat !== 8'h00) begin
      errors++;
      $display("FAIL to_status: rsp_timeout=%b rsp_rdata=%h expected 1 00", tout, rdat);
    end
    step();
`else
    for (int c = 1; c <= 102; c++) begin
      if (rsp_valid === 1'b1 && rsp_at < 0) begin
        rsp_at = c;
        tout   = rsp_timeout;
      end
      if (c > 2 && penable === 1'b1) pen_cnt++;
      step();
    end
    checks++;
    if (rsp_at != -1 || tout !== 1'b0) begin
      errors++;
      $display("FAIL no_to_rsp: unexpected response at +%0d timeout=%b", rsp_at, tout);
    end
    checks++;
    if (pen_cnt != 100 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_to_hold: penable cycles=%0d rsp_timeout=%b expected 100 0", pen_cnt, rsp_timeout);
    end
    pready = 1'b1;
    step();
    pready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL no_to_release: rsp_valid=%b rsp_rdata=%h expected 1 FF", rsp_valid, rsp_rdata);
    end
    step();
`endif
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 8'h00; prdata = 8'h00; pready = 1'b0;
    #2;
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
